// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: unified word RAM serving instruction and data ports, zero-filled by a clear FSM after reset.
module cpu_mem_responder #(
  parameter int WORDS = 16384,
  parameter bit ALIGN_READ = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_read,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_out,
  input  logic        data_read,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        addr_err
);
  localparam int AW = $clog2(WORDS);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [31:0] instr_out_q, instr_out_d, data_out_q, data_out_d;
  logic mem_ready_q, mem_ready_d, addr_err_q, addr_err_d;
  logic [31:0] mem [WORDS];
  logic [AW-1:0] d_idx, i_idx;
  logic d_oor, i_oor, run, wr_en;
  logic [31:0] lane_mask, wr_word, d_word, i_word;
  always_comb begin
    d_idx = data_addr[AW+1:2];
    i_idx = instr_addr[AW+1:2];
    d_oor = |data_addr[31:AW+2];
    i_oor = |instr_addr[31:AW+2];
    run = state_q == RUN;
    wr_en = run && |data_write && !d_oor;
    lane_mask = {{8{data_write[3]}}, {8{data_write[2]}}, {8{data_write[1]}}, {8{data_write[0]}}};
    wr_word = (mem[d_idx] & ~lane_mask) | (data_in & lane_mask);
    // write-first: a same-cycle write to the word being read is forwarded to both ports
    d_word = wr_en ? wr_word : mem[d_idx];
    i_word = (wr_en && i_idx == d_idx) ? wr_word : mem[i_idx];
    state_d = state_q;
    clr_idx_d = clr_idx_q;
    mem_ready_d = mem_ready_q;
    instr_out_d = instr_out_q;
    data_out_d = data_out_q;
    addr_err_d = addr_err_q;
    if (!run) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (!CLEAR_ON_RESET || &clr_idx_q) begin
        state_d = RUN;
        mem_ready_d = 1'b1;
      end
    end else begin
      instr_out_d = instr_read ? (i_oor ? 32'd0 : i_word) : instr_out_q;
      data_out_d = data_read ? (d_oor ? 32'd0 : ALIGN_READ ? d_word >> {data_addr[1:0], 3'b000} : d_word) : data_out_q;
      addr_err_d = addr_err_q | ((data_read || |data_write) && d_oor) | (instr_read && (i_oor || |instr_addr[1:0]));
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_idx_q <= '0;
      mem_ready_q <= 1'b0;
      instr_out_q <= '0;
      data_out_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_idx_q <= clr_idx_d;
      mem_ready_q <= mem_ready_d;
      instr_out_q <= instr_out_d;
      data_out_q <= data_out_d;
      addr_err_q <= addr_err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!run && CLEAR_ON_RESET)
      mem[clr_idx_q] <= '0;
    else if (wr_en)
      mem[d_idx] <= wr_word;
  end
  assign instr_out = instr_out_q;
  assign data_out = data_out_q;
  assign mem_ready = mem_ready_q;
  assign addr_err = addr_err_q;
endmodule
